// File: rtl/fcpu_pkg.sv
// Shared CPU-side types and constants used by the memory management unit and its response FIFO.
package fcpu_pkg;
   localparam int DATA_W        = 32;
   localparam int RSV_ID_W      = 5;
   localparam int INSTR_W       = 6;
   localparam int CDB_W         = RSV_ID_W + DATA_W;
   localparam int MMU_IO_BYTE_W = 8;

   localparam logic [INSTR_W-1:0] I_LOAD    = 6'h10;
   localparam logic [INSTR_W-1:0] I_LOADB   = 6'h11;
   localparam logic [INSTR_W-1:0] I_LOADR   = 6'h12;
   localparam logic [INSTR_W-1:0] I_LOADF   = 6'h13;
   localparam logic [INSTR_W-1:0] I_LOADBF  = 6'h14;
   localparam logic [INSTR_W-1:0] I_LOADRF  = 6'h15;
   localparam logic [INSTR_W-1:0] I_STORE   = 6'h18;
   localparam logic [INSTR_W-1:0] I_STOREB  = 6'h19;
   localparam logic [INSTR_W-1:0] I_STORER  = 6'h1A;
   localparam logic [INSTR_W-1:0] I_STOREF  = 6'h1B;
   localparam logic [INSTR_W-1:0] I_STOREBF = 6'h1C;
   localparam logic [INSTR_W-1:0] I_STORERF = 6'h1D;
   localparam logic [INSTR_W-1:0] I_INPUT   = 6'h20;
   localparam logic [INSTR_W-1:0] I_INPUTF  = 6'h21;
   localparam logic [INSTR_W-1:0] I_OUTPUT  = 6'h22;

   typedef enum logic [1:0] {MMU_IDLE, MMU_RD, MMU_IN, MMU_OUT} mmu_state_t;

   function automatic logic is_load_op(input logic [INSTR_W-1:0] op);
      return op inside {I_LOAD, I_LOADB, I_LOADR, I_LOADF, I_LOADBF, I_LOADRF};
   endfunction

   function automatic logic is_store_op(input logic [INSTR_W-1:0] op);
      return op inside {I_STORE, I_STOREB, I_STORER, I_STOREF, I_STOREBF, I_STORERF};
   endfunction
endpackage

// File: rtl/cdb_fifo.sv
// Small in-order response queue for CDB words; head is zero whenever the queue is empty.
module cdb_fifo #(
   parameter  int WIDTH = 37,
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= bump(wr_ptr);
         if (pop)  rd_ptr <= bump(rd_ptr);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/memory_management_unit.sv
// Responder for core memory/IO requests: data RAM loads/stores, byte input/output streams,
// and in-order CDB results through a response FIFO whose slot is reserved at accept time.
module memory_management_unit
   import fcpu_pkg::*;
#(
   parameter int DRAM_ADDR_W = 17,
   parameter int RESP_DEPTH  = 2
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic [RSV_ID_W-1:0]      i_rsv_id,
   input  logic                     i_valid,
   input  logic [DATA_W-1:0]        i_data,
   input  logic [DATA_W-1:0]        i_addr,
   input  logic [INSTR_W-1:0]       i_opcode,
   output logic                     i_ready,
   output logic [CDB_W-1:0]         o_cdb,
   output logic                     o_cdb_valid,
   input  logic                     o_cdb_ready,
   output logic [DRAM_ADDR_W-1:0]   dram_addr,
   output logic                     dram_we,
   output logic [DATA_W-1:0]        dram_wdata,
   input  logic [DATA_W-1:0]        dram_rdata,
   input  logic [MMU_IO_BYTE_W-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [MMU_IO_BYTE_W-1:0] out_data,
   output logic                     out_valid,
   input  logic                     out_ready
);
   localparam int CNT_W = $clog2(RESP_DEPTH + 1);

   mmu_state_t               state;
   mmu_state_t               next_state;
   logic [1:0]               byte_cnt;
   logic [RSV_ID_W-1:0]      req_rsv;
   logic [MMU_IO_BYTE_W-1:0] req_byte;
   logic                     req_inputf;
   logic [23:0]              in_word;
   logic [CNT_W-1:0]         fifo_count;
   logic                     accept;
   logic                     push;
   logic                     pop;
   logic [CDB_W-1:0]         push_data;
   logic                     unused_addr;

   // Upper address bits are ignored: the RAM address space wraps.
   assign unused_addr = ^i_addr[DATA_W-1:DRAM_ADDR_W];

   assign i_ready     = nrst && (state == MMU_IDLE) && (fifo_count < CNT_W'(RESP_DEPTH));
   assign accept      = i_valid && i_ready;
   assign dram_addr   = i_addr[DRAM_ADDR_W-1:0];
   assign dram_wdata  = i_data;
   assign o_cdb_valid = (fifo_count != '0);
   assign pop         = o_cdb_valid && o_cdb_ready;
   assign out_data    = req_byte;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= MMU_IDLE;
         byte_cnt <= '0;
      end else begin
         state <= next_state;
         if (accept)
            byte_cnt <= '0;
         else if (state == MMU_IN && in_valid && byte_cnt != 2'd3)
            byte_cnt <= byte_cnt + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         req_rsv    <= i_rsv_id;
         req_byte   <= i_data[MMU_IO_BYTE_W-1:0];
         req_inputf <= (i_opcode == I_INPUTF);
      end
      if (state == MMU_IN && in_valid) begin
         case (byte_cnt)
            2'd0:    in_word[7:0]   <= in_data;
            2'd1:    in_word[15:8]  <= in_data;
            2'd2:    in_word[23:16] <= in_data;
            default: ;
         endcase
      end
   end

   always_comb begin
      next_state = state;
      dram_we    = 1'b0;
      push       = 1'b0;
      push_data  = '0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         MMU_IDLE: begin
            if (accept) begin
               if (is_store_op(i_opcode))
                  dram_we = 1'b1;
               else if (is_load_op(i_opcode))
                  next_state = MMU_RD;
               else if (i_opcode == I_INPUT || i_opcode == I_INPUTF)
                  next_state = MMU_IN;
               else if (i_opcode == I_OUTPUT)
                  next_state = MMU_OUT;
            end
         end
         MMU_RD: begin
            push       = 1'b1;
            push_data  = {req_rsv, dram_rdata};
            next_state = MMU_IDLE;
         end
         MMU_IN: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (!req_inputf) begin
                  push       = 1'b1;
                  push_data  = {req_rsv, 24'b0, in_data};
                  next_state = MMU_IDLE;
               end else if (byte_cnt == 2'd3) begin
                  push       = 1'b1;
                  push_data  = {req_rsv, in_data, in_word};
                  next_state = MMU_IDLE;
               end
            end
         end
         MMU_OUT: begin
            out_valid = 1'b1;
            if (out_ready) next_state = MMU_IDLE;
         end
         default: next_state = MMU_IDLE;
      endcase
   end

   cdb_fifo #(.WIDTH(CDB_W), .DEPTH(RESP_DEPTH)) resp_fifo (
      .clk       (clk),
      .nrst      (nrst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (o_cdb),
      .count     (fifo_count)
   );
endmodule

// File: tb/tb_memory_management_unit.sv
// Scoreboard bench for memory_management_unit: directed scenarios followed by randomized traffic.
module tb_memory_management_unit;
   import fcpu_pkg::*;

   localparam int AW    = 17;
   localparam int DEPTH = 2;

   logic                 clk = 1'b0;
   logic                 nrst;
   logic [RSV_ID_W-1:0]  i_rsv_id;
   logic                 i_valid;
   logic [DATA_W-1:0]    i_data;
   logic [DATA_W-1:0]    i_addr;
   logic [INSTR_W-1:0]   i_opcode;
   logic                 i_ready;
   logic [CDB_W-1:0]     o_cdb;
   logic                 o_cdb_valid;
   logic                 o_cdb_ready;
   logic [AW-1:0]        dram_addr;
   logic                 dram_we;
   logic [DATA_W-1:0]    dram_wdata;
   logic [DATA_W-1:0]    dram_rdata;
   logic [7:0]           in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [7:0]           out_data;
   logic                 out_valid;
   logic                 out_ready;

   memory_management_unit #(.DRAM_ADDR_W(AW), .RESP_DEPTH(DEPTH)) dut (
      .clk(clk), .nrst(nrst), .i_rsv_id(i_rsv_id), .i_valid(i_valid), .i_data(i_data),
      .i_addr(i_addr), .i_opcode(i_opcode), .i_ready(i_ready), .o_cdb(o_cdb),
      .o_cdb_valid(o_cdb_valid), .o_cdb_ready(o_cdb_ready), .dram_addr(dram_addr),
      .dram_we(dram_we), .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int we_cnt   = 0;
   int n;
   bit auto_ready = 1'b0;
   bit auto_out   = 1'b0;

   logic [CDB_W-1:0]  exp_q[$];
   logic [7:0]        out_exp[$];
   logic [7:0]        in_q[$];
   logic [DATA_W-1:0] model_mem [int];
   logic [DATA_W-1:0] ram [int];

   logic [INSTR_W-1:0] loads  [6] = '{I_LOAD, I_LOADB, I_LOADR, I_LOADF, I_LOADBF, I_LOADRF};
   logic [INSTR_W-1:0] stores [6] = '{I_STORE, I_STOREB, I_STORER, I_STOREF, I_STOREBF, I_STORERF};

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, got, want);
   endtask

   // Synchronous write-first data RAM, one-cycle read latency.
   always @(posedge clk) begin
      if (dram_we) begin
         ram[int'(dram_addr)] = dram_wdata;
         dram_rdata <= dram_wdata;
      end else begin
         dram_rdata <= ram.exists(int'(dram_addr)) ? ram[int'(dram_addr)] : '0;
      end
   end

   always @(posedge clk) cyc++;
   always @(negedge clk) if (dram_we) we_cnt++;

   always @(negedge clk) begin
      if (nrst && o_cdb_valid && o_cdb_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL cdb_unexpected: got %0h, expected no response", o_cdb);
         end else begin
            check("cdb", 64'(o_cdb), 64'(exp_q.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (nrst && out_valid && out_ready) begin
         if (out_exp.size() == 0) begin
            n_checks++;
            $display("FAIL out_unexpected: got %0h, expected no byte", out_data);
         end else begin
            check("out_byte", 64'(out_data), 64'(out_exp.pop_front()));
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (auto_ready) o_cdb_ready = ($urandom_range(0, 3) != 0);
      if (auto_out)   out_ready   = ($urandom_range(0, 2) != 0);
   end

   // Input byte source: offers queued bytes with random gaps.
   initial begin
      bit fire;
      in_valid = 1'b0;
      in_data  = '0;
      forever begin
         @(negedge clk);
         fire = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (fire && in_q.size() > 0) void'(in_q.pop_front());
         if (in_q.size() > 0 && $urandom_range(0, 2) != 0) begin
            in_valid = 1'b1;
            in_data  = in_q[0];
         end else begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
         end
      end
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: run exceeded cycle budget, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   task automatic issue(input logic [INSTR_W-1:0] op, input logic [DATA_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input logic [RSV_ID_W-1:0] rsv);
      int waited = 0;
      i_valid  = 1'b1;
      i_opcode = op;
      i_addr   = addr;
      i_data   = data;
      i_rsv_id = rsv;
      @(negedge clk);
      while (!i_ready && waited < 500) begin
         waited++;
         @(negedge clk);
      end
      if (!i_ready) begin
         n_checks++;
         $display("FAIL accept_timeout: i_ready stayed 0, expected 1 for op %0h", op);
      end
      @(posedge clk);
      #1;
      i_valid = 1'b0;
   endtask

   // Reference model: RAM contents by wrapped word address, byte streams as queues.
   task automatic do_req(input logic [INSTR_W-1:0] op, input logic [DATA_W-1:0] addr,
                         input logic [DATA_W-1:0] data, input logic [RSV_ID_W-1:0] rsv);
      int key = int'(addr[AW-1:0]);
      if (op inside {I_STORE, I_STOREB, I_STORER, I_STOREF, I_STOREBF, I_STORERF}) begin
         model_mem[key] = data;
      end else if (op inside {I_LOAD, I_LOADB, I_LOADR, I_LOADF, I_LOADBF, I_LOADRF}) begin
         exp_q.push_back({rsv, (model_mem.exists(key) ? model_mem[key] : 32'h0)});
      end else if (op == I_INPUT) begin
         in_q.push_back(data[7:0]);
         exp_q.push_back({rsv, 24'h0, data[7:0]});
      end else if (op == I_INPUTF) begin
         for (int b = 0; b < 4; b++) in_q.push_back(data[8*b +: 8]);
         exp_q.push_back({rsv, data});
      end else if (op == I_OUTPUT) begin
         out_exp.push_back(data[7:0]);
      end
      issue(op, addr, data, rsv);
   endtask

   initial begin
      int c0;
      int w0;
      nrst        = 1'b0;
      i_valid     = 1'b0;
      i_rsv_id    = '0;
      i_data      = '0;
      i_addr      = '0;
      i_opcode    = '0;
      o_cdb_ready = 1'b1;
      out_ready   = 1'b0;

      @(negedge clk);
      @(negedge clk);
      i_valid  = 1'b1;
      i_opcode = I_STORE;
      #1;
      check("rst_i_ready", i_ready, 0);
      check("rst_cdb_valid", o_cdb_valid, 0);
      check("rst_cdb", o_cdb, 0);
      check("rst_dram_we", dram_we, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      i_valid = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
      @(posedge clk);
      #1;

      // Store then immediate load of the same address.
      o_cdb_ready = 1'b1;
      do_req(I_STORE, 32'h10, 32'hDEADBEEF, 5'd0);
      do_req(I_LOAD, 32'h10, 32'h0, 5'd5);
      @(negedge clk);
      check("t1_valid_cycle1", o_cdb_valid, 0);
      @(negedge clk);
      check("t1_valid_cycle2", o_cdb_valid, 1);
      check("t1_cdb", o_cdb, {5'd5, 32'hDEADBEEF});
      repeat (2) @(posedge clk);
      #1;

      // Four back-to-back stores.
      c0 = cyc;
      w0 = we_cnt;
      for (int k = 0; k < 4; k++) do_req(stores[k], 32'h20 + k, 32'hA000_0000 + k, 5'(k));
      check("t2_cycles", 64'(cyc - c0), 4);
      check("t2_we_pulses", 64'(we_cnt - w0), 4);

      // FIFO fills with core not ready.
      o_cdb_ready = 1'b0;
      do_req(I_LOAD, 32'h10, 32'h0, 5'd1);
      do_req(I_LOADB, 32'h21, 32'h0, 5'd2);
      repeat (3) @(negedge clk);
      check("t3_i_ready_full", i_ready, 0);
      check("t3_cdb_valid", o_cdb_valid, 1);
      check("t3_head", o_cdb, {5'd1, 32'hDEADBEEF});
      @(posedge clk);
      #1;
      o_cdb_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      check("t3_i_ready_after", i_ready, 1);
      check("t3_cdb_valid_after", o_cdb_valid, 0);

      // INPUTF assembly with gaps.
      @(posedge clk);
      #1;
      do_req(I_INPUTF, 32'h0, 32'h12345678, 5'd3);
      n = 0;
      @(negedge clk);
      while (!o_cdb_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t4_cdb", o_cdb, {5'd3, 32'h12345678});
      check("t4_bytes_left", 64'(in_q.size()), 0);
      @(posedge clk);
      #1;

      // OUTPUT held while the sink stalls.
      out_ready = 1'b0;
      do_req(I_OUTPUT, 32'h0, 32'h141, 5'd4);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t5_out_valid", out_valid, 1);
         check("t5_out_data", out_data, 8'h41);
         check("t5_i_ready", i_ready, 0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("t5_i_ready_after", i_ready, 1);
      check("t5_out_valid_after", out_valid, 0);
      @(posedge clk);
      #1;

      // Reset in the middle of INPUTF with a queued response.
      o_cdb_ready = 1'b0;
      do_req(I_LOADR, 32'h22, 32'h0, 5'd9);
      in_q.push_back(8'hAA);
      in_q.push_back(8'hBB);
      issue(I_INPUTF, 32'h0, 32'h0, 5'd7);
      n = 0;
      while (in_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      check("t6_pre_in_ready", in_ready, 1);
      check("t6_pre_cdb_valid", o_cdb_valid, 1);
      nrst = 1'b0;
      #1;
      check("t6_rst_cdb_valid", o_cdb_valid, 0);
      check("t6_rst_cdb", o_cdb, 0);
      check("t6_rst_in_ready", in_ready, 0);
      check("t6_rst_i_ready", i_ready, 0);
      exp_q.delete();
      in_q.delete();
      @(posedge clk);
      #2;
      nrst = 1'b1;
      @(negedge clk);
      check("t6_i_ready_after", i_ready, 1);
      check("t6_cdb_valid_after", o_cdb_valid, 0);
      check("t6_in_ready_after", in_ready, 0);
      @(posedge clk);
      #1;

      // Randomized traffic.
      auto_ready = 1'b1;
      auto_out   = 1'b1;
      for (int k = 0; k < 300; k++) begin
         logic [DATA_W-1:0] a;
         logic [DATA_W-1:0] d;
         logic [RSV_ID_W-1:0] r;
         int sel;
         a   = (DATA_W'($urandom_range(0, 3)) << AW) | DATA_W'($urandom_range(0, 15));
         d   = $urandom;
         r   = RSV_ID_W'($urandom_range(0, 31));
         sel = $urandom_range(0, 9);
         if (sel <= 2)      do_req(stores[$urandom_range(0, 5)], a, d, r);
         else if (sel <= 5) do_req(loads[$urandom_range(0, 5)], a, d, r);
         else if (sel == 6) do_req(I_INPUT, a, d, r);
         else if (sel == 7) do_req(I_INPUTF, a, d, r);
         else if (sel == 8) do_req(I_OUTPUT, a, d, r);
         else               do_req(($urandom_range(0, 1) != 0) ? 6'h00 : 6'h3F, a, d, r);
      end
      n = 0;
      while ((exp_q.size() != 0 || out_exp.size() != 0) && n < 3000) begin
         @(posedge clk);
         n++;
      end
      repeat (5) @(posedge clk);
      check("drain_cdb", 64'(exp_q.size()), 0);
      check("drain_out", 64'(out_exp.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
